// File: rtl/mac_array_ctrl_if.sv
// Command/SRAM/column-control bundle between the core controller and mac_array_ctrl.
// The master side is the core controller; mac_array_ctrl attaches through the slave modport.
interface mac_array_ctrl_if #(
    parameter int addr_bw = 11
);
    logic               start;
    logic [addr_bw-1:0] key_base;
    logic [addr_bw-1:0] q_base;
    logic [addr_bw-1:0] q_len;
    logic               ofifo_full;
    logic               mem_rd;
    logic [addr_bw-1:0] mem_addr;
    logic               mac_rst;
    logic [1:0]         inst;
    logic               busy;
    logic               done;

    modport master (
        output start, key_base, q_base, q_len, ofifo_full,
        input  mem_rd, mem_addr, mac_rst, inst, busy, done
    );

    modport slave (
        input  start, key_base, q_base, q_len, ofifo_full,
        output mem_rd, mem_addr, mac_rst, inst, busy, done
    );
endinterface

// File: rtl/mac_array_ctrl.sv
// Pass sequencer for a mac_col chain: key load, query execute with FIFO throttling, drain.
// The instruction word is registered so it lines up with SRAM data returned one cycle later.
module mac_array_ctrl #(
    parameter int col       = 8,
    parameter int addr_bw   = 11,
    parameter int load_cyc  = 10,
    parameter int drain_cyc = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_array_ctrl_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_KLOAD, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    localparam logic [addr_bw-1:0] ONE        = addr_bw'(1);
    localparam logic [addr_bw-1:0] LOAD_LAST  = addr_bw'(load_cyc - 1);
    localparam logic [addr_bw-1:0] DRAIN_LAST = addr_bw'(drain_cyc - 1);

    // Shorter windows would leave the far columns without a key or a flushed result.
    if (load_cyc < col + 2 || drain_cyc < col + 2) begin : g_bad_params
        $error("mac_array_ctrl: load_cyc and drain_cyc must be >= col+2");
    end

    state_t             state_q, state_d;
    logic [addr_bw-1:0] cnt_q, cnt_d;
    logic [addr_bw-1:0] j_q, j_d;
    logic [addr_bw-1:0] key_base_q, key_base_d;
    logic [addr_bw-1:0] q_base_q, q_base_d;
    logic [addr_bw-1:0] q_len_q, q_len_d;
    logic [1:0]         inst_q, inst_d;

    logic               mem_rd;
    logic [addr_bw-1:0] mem_addr;
    logic               mac_rst;
    logic               done;
    logic               rd_kload;
    logic               rd_exec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            j_q        <= '0;
            key_base_q <= '0;
            q_base_q   <= '0;
            q_len_q    <= '0;
            inst_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            j_q        <= j_d;
            key_base_q <= key_base_d;
            q_base_q   <= q_base_d;
            q_len_q    <= q_len_d;
            inst_q     <= inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        j_d        = j_q;
        key_base_d = key_base_q;
        q_base_d   = q_base_q;
        q_len_d    = q_len_q;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        mac_rst    = 1'b0;
        done       = 1'b0;
        rd_kload   = 1'b0;
        rd_exec    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    key_base_d = bus.key_base;
                    q_base_d   = bus.q_base;
                    q_len_d    = bus.q_len;
                    cnt_d      = '0;
                    j_d        = '0;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                mac_rst = 1'b1;
                cnt_d   = '0;
                state_d = S_KLOAD;
            end
            S_KLOAD: begin
                mem_rd   = 1'b1;
                rd_kload = 1'b1;
                mem_addr = key_base_q + cnt_q;
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (q_len_q != '0) ? S_EXEC : S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_EXEC: begin
                // A full output FIFO inserts a bubble: no read, query index holds.
                if (!bus.ofifo_full) begin
                    mem_rd   = 1'b1;
                    rd_exec  = 1'b1;
                    mem_addr = q_base_q + j_q;
                    j_d      = j_q + ONE;
                    if (j_q == q_len_q - ONE) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_d = {rd_exec, rd_kload};

    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = mem_addr;
    assign bus.mac_rst  = mac_rst;
    assign bus.inst     = inst_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: reset abort, nominal, backpressure, empty and wrap passes.
module tb_mac_array_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    mac_array_ctrl_if #(.addr_bw(11)) bus ();

    mac_array_ctrl #(.col(8), .addr_bw(11), .load_cyc(10), .drain_cyc(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rd_t   [64];
    logic [10:0] addr_t [64];
    logic [1:0]  inst_t [64];
    logic        mrst_t [64];
    logic        done_t [64];
    logic        busy_t [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rec(input int c);
        rd_t[c]   = bus.mem_rd;
        addr_t[c] = bus.mem_addr;
        inst_t[c] = bus.inst;
        mrst_t[c] = bus.mac_rst;
        done_t[c] = bus.done;
        busy_t[c] = bus.busy;
    endtask

    // Cycle 0 is the cycle in which start is presented; outputs sampled mid-cycle.
    task automatic run_pass(input logic [10:0] kb, input logic [10:0] qb, input logic [10:0] ql,
                            input int stall_lo, input int stall_hi, input int restart_at);
        @(negedge clk);
        bus.key_base   = kb;
        bus.q_base     = qb;
        bus.q_len      = ql;
        bus.start      = 1'b1;
        bus.ofifo_full = 1'b0;
        #1 rec(0);
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            bus.start      = (c == restart_at);
            bus.ofifo_full = (c >= stall_lo) && (c <= stall_hi);
            #1 rec(c);
        end
        bus.start      = 1'b0;
        bus.ofifo_full = 1'b0;
    endtask

    function automatic int first_done();
        for (int c = 0; c < 40; c++) if (done_t[c]) return c;
        return -1;
    endfunction

    function automatic int count_inst(input logic [1:0] v);
        int n = 0;
        for (int c = 0; c < 40; c++) if (inst_t[c] == v) n++;
        return n;
    endfunction

    function automatic int count_bits(input int which);
        int n = 0;
        for (int c = 0; c < 40; c++) begin
            if (which == 0 && done_t[c]) n++;
            if (which == 1 && mrst_t[c]) n++;
            if (which == 2 && rd_t[c])   n++;
        end
        return n;
    endfunction

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.key_base   = '0;
        bus.q_base     = '0;
        bus.q_len      = '0;
        bus.ofifo_full = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mac_rst", bus.mac_rst, 0);
        reset = 1'b1;

        // 1: reset asserted mid-KLOAD aborts at once
        @(negedge clk);
        bus.key_base = 11'h010;
        bus.q_base   = 11'h040;
        bus.q_len    = 11'd4;
        bus.start    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        chk("t1_pre_rd", bus.mem_rd, 1);
        chk("t1_pre_addr", bus.mem_addr, 11'h013);
        chk("t1_pre_inst", bus.inst, 2'b01);
        #1 reset = 1'b0;
        #1;
        chk("t1_abort_rd", bus.mem_rd, 0);
        chk("t1_abort_inst", bus.inst, 0);
        chk("t1_abort_busy", bus.busy, 0);
        chk("t1_abort_addr", bus.mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("t1_post_busy", bus.busy, 0);
        chk("t1_post_rd", bus.mem_rd, 0);
        chk("t1_post_done", bus.done, 0);

        // 2: nominal pass
        run_pass(11'h010, 11'h040, 11'd4, 100, 100, -1);
        chk("t2_busy0", busy_t[0], 0);
        chk("t2_busy1", busy_t[1], 1);
        chk("t2_mac_rst1", mrst_t[1], 1);
        chk("t2_mac_rst_n", count_bits(1), 1);
        chk("t2_inst_arm", inst_t[1], 0);
        for (int c = 2; c <= 11; c++) begin
            chk($sformatf("t2_krd@%0d", c), rd_t[c], 1);
            chk($sformatf("t2_kaddr@%0d", c), addr_t[c], 11'h010 + c - 2);
        end
        for (int c = 3; c <= 12; c++) chk($sformatf("t2_inst01@%0d", c), inst_t[c], 2'b01);
        for (int c = 12; c <= 15; c++) begin
            chk($sformatf("t2_qrd@%0d", c), rd_t[c], 1);
            chk($sformatf("t2_qaddr@%0d", c), addr_t[c], 11'h040 + c - 12);
        end
        for (int c = 13; c <= 16; c++) chk($sformatf("t2_inst10@%0d", c), inst_t[c], 2'b10);
        chk("t2_drain_rd", rd_t[16], 0);
        chk("t2_drain_inst", inst_t[17], 0);
        chk("t2_rd_count", count_bits(2), 14);
        chk("t2_done_at", first_done(), 26);
        chk("t2_done_n", count_bits(0), 1);
        chk("t2_busy26", busy_t[26], 1);
        chk("t2_busy27", busy_t[27], 0);

        // 3: backpressure in EXEC cycles 2-3 (absolute 14-15)
        run_pass(11'h020, 11'h100, 11'd3, 14, 15, -1);
        chk("t3_a0", addr_t[12], 11'h100);
        chk("t3_a1", addr_t[13], 11'h101);
        chk("t3_stall_rd14", rd_t[14], 0);
        chk("t3_stall_rd15", rd_t[15], 0);
        chk("t3_rd16", rd_t[16], 1);
        chk("t3_a2", addr_t[16], 11'h102);
        chk("t3_bubble_inst15", inst_t[15], 0);
        chk("t3_bubble_inst16", inst_t[16], 0);
        chk("t3_inst17", inst_t[17], 2'b10);
        chk("t3_inst10_n", count_inst(2'b10), 3);
        chk("t3_done_at", first_done(), 27);

        // 4: empty pass; ofifo_full during KLOAD has no effect
        run_pass(11'h005, 11'h300, 11'd0, 3, 8, -1);
        chk("t4_inst10_n", count_inst(2'b10), 0);
        chk("t4_inst01_n", count_inst(2'b01), 10);
        chk("t4_rd_count", count_bits(2), 10);
        chk("t4_krd5", rd_t[5], 1);
        chk("t4_kaddr5", addr_t[5], 11'h008);
        chk("t4_done_at", first_done(), 22);

        // 5: query address wrap and a start pulse mid-pass
        run_pass(11'h7FB, 11'h7FE, 11'd3, 100, 100, 8);
        chk("t5_kaddr6", addr_t[6], 11'h7FF);
        chk("t5_kaddr7", addr_t[7], 11'h000);
        chk("t5_q0", addr_t[12], 11'h7FE);
        chk("t5_q1", addr_t[13], 11'h7FF);
        chk("t5_q2", addr_t[14], 11'h000);
        chk("t5_mac_rst_n", count_bits(1), 1);
        chk("t5_done_n", count_bits(0), 1);
        chk("t5_done_at", first_done(), 25);
        chk("t5_idle_busy", busy_t[39], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
